// File: rtl/cpu_pkg.sv
// Shared types and constants for the 32-bit CPU front end.
// Provides the instruction-memory geometry, the fetch FSM state encoding and
// the {pc, instr} record carried through the fetch queue.
package cpu_pkg;

    localparam int IMEM_AW = 6;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_HALT
    } fetch_state_t;

    typedef struct packed {
        logic [IMEM_AW-1:0] pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry synchronous FIFO of {pc, instr} records.
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   push     - write din (ignored when full unless a pop happens the same edge)
//   pop      - drop the head (ignored when empty)
//   flush    - discard all entries; overrides push, may coincide with pop
//   din      - record to write
//   full     - two entries held
//   empty    - no entries held
//   head     - oldest record (registered)
module fetch_queue
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    logic [1:0]   count;
    fetch_entry_t ent0;
    fetch_entry_t ent1;
    logic         pop_ok;
    logic         push_ok;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign head    = ent0;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ent0  <= '0;
            ent1  <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (empty) ent0 <= din;
                    else       ent1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    ent0  <= ent1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Single entry: new word becomes head; full: shift and refill tail.
                    if (count == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/insmem.sv
// 64-word instruction ROM, combinational read.
// Ports:
//   addr_code - word address from the fetch sequencer
//   code      - instruction word at addr_code
// Contents are a fixed address-derived pattern so every word is distinct.
module insmem
    import cpu_pkg::*;
(
    input  logic [IMEM_AW-1:0] addr_code,
    output logic [INSTR_W-1:0] code
);

    assign code = 32'hC0DE_0000
                ^ {addr_code, addr_code, addr_code, addr_code, addr_code, 2'b01};

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives insmem, buffers fetched
// words in a 2-entry queue and hands them to decode via valid/ready.
// Ports:
//   clk, rst        - clock and synchronous active-high reset
//   start           - IDLE/HALT -> RUN
//   halt_req        - stop fetching (queue keeps draining)
//   redirect_valid  - branch/jump taken: flush queue, load redirect_addr
//   redirect_addr   - target word address
//   addr_code       - PC, address to insmem
//   code            - insmem word at addr_code
//   instr, instr_pc - queue head word and its address
//   instr_valid     - queue non-empty
//   instr_ready     - decode accepts the head
//   halted          - FSM in HALT
module fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [IMEM_AW-1:0] RESET_PC = '0,
    parameter bit                 WRAP     = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               halt_req,
    input  logic               redirect_valid,
    input  logic [IMEM_AW-1:0] redirect_addr,
    output logic [IMEM_AW-1:0] addr_code,
    input  logic [INSTR_W-1:0] code,
    output logic [INSTR_W-1:0] instr,
    output logic [IMEM_AW-1:0] instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic               halted
);

    fetch_state_t       state;
    fetch_state_t       state_nxt;
    logic [IMEM_AW-1:0] pc;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic               wrap_stop;
    fetch_entry_t       head;
    fetch_entry_t       din;

    assign pop       = ~empty & instr_ready;
    assign wrap_stop = push & (pc == '1) & ~WRAP;
    assign din       = '{pc: pc, instr: code};

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE: begin
                if (!redirect_valid && !halt_req && start)
                    state_nxt = FETCH_RUN;
            end
            FETCH_RUN: begin
                if (halt_req || wrap_stop)
                    state_nxt = FETCH_HALT;
            end
            FETCH_HALT: begin
                if (!redirect_valid && !halt_req && start)
                    state_nxt = FETCH_RUN;
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    always_comb begin
        push   = (state == FETCH_RUN) & ~redirect_valid & ~halt_req & (~full | pop);
        halted = (state == FETCH_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst)                      pc <= RESET_PC;
        else if (redirect_valid)      pc <= redirect_addr;
        else if (push && !wrap_stop)  pc <= pc + 1'b1;
    end

    fetch_queue u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (din),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    assign addr_code   = pc;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_valid = ~empty;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl with insmem attached.
// dut_a runs with WRAP=1, dut_b with WRAP=0 (wrap-stop case only).
module tb_fetch_ctrl;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_start, a_halt, a_redir, a_ready, a_valid, a_halted;
    logic [5:0]  a_raddr, a_addr, a_instr_pc;
    logic [31:0] a_code, a_instr;
    logic        b_rst, b_start, b_halt, b_redir, b_ready, b_valid, b_halted;
    logic [5:0]  b_raddr, b_addr, b_instr_pc;
    logic [31:0] b_code, b_instr;

    int checks = 0;
    int errors = 0;
    logic [5:0] sb_a[$];
    logic [5:0] sb_b[$];
    logic [5:0] exp_a, exp_b;

    fetch_ctrl #(.RESET_PC(6'd0), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .halt_req(a_halt),
        .redirect_valid(a_redir), .redirect_addr(a_raddr), .addr_code(a_addr),
        .code(a_code), .instr(a_instr), .instr_pc(a_instr_pc),
        .instr_valid(a_valid), .instr_ready(a_ready), .halted(a_halted)
    );
    insmem u_mem_a (.addr_code(a_addr), .code(a_code));

    fetch_ctrl #(.RESET_PC(6'd0), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .halt_req(b_halt),
        .redirect_valid(b_redir), .redirect_addr(b_raddr), .addr_code(b_addr),
        .code(b_code), .instr(b_instr), .instr_pc(b_instr_pc),
        .instr_valid(b_valid), .instr_ready(b_ready), .halted(b_halted)
    );
    insmem u_mem_b (.addr_code(b_addr), .code(b_code));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference ROM contents: the address replicated in five 6-bit fields above 2'b01.
    function automatic logic [31:0] memw(input logic [5:0] a);
        logic [31:0] r;
        r = 32'd1;
        for (int k = 0; k < 5; k++) r = r | (32'(a) << (2 + 6 * k));
        return r ^ 32'hC0DE_0000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input logic [5:0] pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (a_valid === 1'b1 && a_instr_pc == pc) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("a_wait_head", 32'(found), 32'd1);
    endtask

    // Handshake monitors: every delivered head must match the scoreboard order.
    always @(negedge clk) begin
        if (a_valid === 1'b1 && a_ready === 1'b1) begin
            check("a_sb_avail", 32'(sb_a.size() != 0), 32'd1);
            if (sb_a.size() != 0) begin
                exp_a = sb_a.pop_front();
                check("a_instr_pc", 32'(a_instr_pc), 32'(exp_a));
                check("a_instr", a_instr, memw(exp_a));
            end
        end
        if (b_valid === 1'b1 && b_ready === 1'b1) begin
            check("b_sb_avail", 32'(sb_b.size() != 0), 32'd1);
            if (sb_b.size() != 0) begin
                exp_b = sb_b.pop_front();
                check("b_instr_pc", 32'(b_instr_pc), 32'(exp_b));
                check("b_instr", b_instr, memw(exp_b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        a_rst = 1; a_start = 0; a_halt = 0; a_redir = 0; a_raddr = '0; a_ready = 0;
        b_rst = 1; b_start = 0; b_halt = 0; b_redir = 0; b_raddr = '0; b_ready = 0;
        tick(); tick();

        check("rst_addr", 32'(a_addr), 32'd0);
        check("rst_valid", 32'(a_valid), 32'd0);
        check("rst_instr", a_instr, 32'd0);
        check("rst_instr_pc", 32'(a_instr_pc), 32'd0);
        check("rst_halted", 32'(a_halted), 32'd0);

        a_rst = 0; a_ready = 1;
        tick(); tick();
        check("idle_addr", 32'(a_addr), 32'd0);
        check("idle_valid", 32'(a_valid), 32'd0);

        // Start and stream from 0
        for (int p = 0; p < 4; p++) sb_a.push_back(6'(p));
        a_start = 1; tick(); a_start = 0;
        check("start_valid_e", 32'(a_valid), 32'd0);
        check("start_addr_e", 32'(a_addr), 32'd0);
        tick();
        check("start_valid_e1", 32'(a_valid), 32'd1);
        check("start_pc_e1", 32'(a_instr_pc), 32'd0);
        check("start_addr_e1", 32'(a_addr), 32'd1);

        // Redirect while popping pc 3
        wait_a(6'd3);
        for (int p = 20; p < 23; p++) sb_a.push_back(6'(p));
        a_redir = 1; a_raddr = 6'd20; tick(); a_redir = 0;
        check("redir_valid_gap", 32'(a_valid), 32'd0);
        check("redir_addr", 32'(a_addr), 32'd20);
        tick();
        check("redir_valid", 32'(a_valid), 32'd1);
        check("redir_head", 32'(a_instr_pc), 32'd20);

        // Backpressure from pc 4
        wait_a(6'd22);
        a_redir = 1; a_raddr = 6'd4; tick(); a_redir = 0; a_ready = 0;
        check("bp_valid0", 32'(a_valid), 32'd0);
        check("bp_addr0", 32'(a_addr), 32'd4);
        tick(); tick(); tick(); tick();
        check("bp_addr_hold", 32'(a_addr), 32'd6);
        check("bp_valid", 32'(a_valid), 32'd1);
        check("bp_head", 32'(a_instr_pc), 32'd4);
        for (int p = 4; p < 10; p++) sb_a.push_back(6'(p));
        a_ready = 1;

        // Halt with a full queue at pc 10
        wait_a(6'd9);
        a_redir = 1; a_raddr = 6'd8; tick(); a_redir = 0; a_ready = 0;
        tick(); tick(); tick();
        check("halt_pre_addr", 32'(a_addr), 32'd10);
        a_halt = 1; tick(); a_halt = 0;
        check("halt_halted", 32'(a_halted), 32'd1);
        check("halt_addr", 32'(a_addr), 32'd10);
        check("halt_valid", 32'(a_valid), 32'd1);
        sb_a.push_back(6'd8); sb_a.push_back(6'd9);
        a_ready = 1;
        tick(); tick();
        check("halt_drained", 32'(a_valid), 32'd0);
        check("halt_addr_hold", 32'(a_addr), 32'd10);
        tick();
        check("halt_still", 32'(a_halted), 32'd1);
        check("halt_addr_hold2", 32'(a_addr), 32'd10);
        for (int p = 10; p < 13; p++) sb_a.push_back(6'(p));
        a_start = 1; tick(); a_start = 0;
        check("resume_halted", 32'(a_halted), 32'd0);

        // Wrap 62 -> 63 -> 0 -> 1
        wait_a(6'd12);
        sb_a.push_back(6'd62); sb_a.push_back(6'd63); sb_a.push_back(6'd0);
        a_redir = 1; a_raddr = 6'd62; tick(); a_redir = 0;
        wait_a(6'd1);
        check("wrap_head", 32'(a_instr), memw(6'd1));
        a_ready = 0;
        tick(); tick();
        check("full_valid", 32'(a_valid), 32'd1);
        check("full_addr", 32'(a_addr), 32'd3);

        // Reset with a full queue
        a_rst = 1; tick(); a_rst = 0; a_ready = 1;
        check("mrst_valid", 32'(a_valid), 32'd0);
        check("mrst_addr", 32'(a_addr), 32'd0);
        check("mrst_halted", 32'(a_halted), 32'd0);
        tick(); tick(); tick();
        check("mrst_idle_valid", 32'(a_valid), 32'd0);
        check("mrst_idle_addr", 32'(a_addr), 32'd0);
        check("a_sb_empty", 32'(sb_a.size()), 32'd0);

        // WRAP=0: stop after fetching 63
        b_rst = 0; b_ready = 1; tick();
        b_start = 1; tick(); b_start = 0;
        sb_b.push_back(6'd62); sb_b.push_back(6'd63);
        b_redir = 1; b_raddr = 6'd62; tick(); b_redir = 0;
        check("b_redir_addr", 32'(b_addr), 32'd62);
        tick();
        check("b_halted_62", 32'(b_halted), 32'd0);
        check("b_addr_63", 32'(b_addr), 32'd63);
        tick();
        check("b_halted_63", 32'(b_halted), 32'd1);
        check("b_addr_stop", 32'(b_addr), 32'd63);
        tick(); tick();
        check("b_addr_hold", 32'(b_addr), 32'd63);
        check("b_valid_end", 32'(b_valid), 32'd0);
        check("b_sb_empty", 32'(sb_b.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 64-word instruction memory (`insmem`). It owns the program counter and drives `addr_code`, and it captures the combinational `code` word into a 2-entry instruction queue. It presents instructions to decode through a valid/ready handshake and handles branch/jump redirects and halt requests. It sits between `insmem` and the decode stage of the 32-bit CPU.

## Interface
Parameters:
- `RESET_PC`, 6'd0: PC value loaded at reset.
- `WRAP`, 1: 1 means the PC wraps from 63 to 0; 0 means the block enters HALT after fetching address 63.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: moves IDLE or HALT to RUN.
- `halt_req`, input, 1: stops fetching; the queue keeps draining.
- `redirect_valid`, input, 1: branch/jump taken.
- `redirect_addr`, input, 6: target word address.
- `addr_code`, output, 6: address to `insmem`; equals the PC register.
- `code`, input, 32: instruction word from `insmem`, combinational in `addr_code`.
- `instr`, output, 32: queue head instruction.
- `instr_pc`, output, 6: address of the queue head.
- `instr_valid`, output, 1: queue is non-empty.
- `instr_ready`, input, 1: decode accepts the head.
- `halted`, output, 1: high in the HALT state.

## Operation
- States are IDLE, RUN and HALT. Reset enters IDLE.
- **IDLE**
  - No fetch.
  - `start` moves the block to RUN.
- **RUN**
  - Push condition: no redirect, and the queue is not full, or it is full and a pop happens this cycle.
  - On push: {`addr_code`, `code`} is written into the queue and PC becomes PC+1.
  - If the queue is full and there is no pop, the PC holds. `addr_code` stays stable while stalled.
- **Wrap**
  - With `WRAP`=1: PC 63+1 becomes 0.
  - With `WRAP`=0: a push at PC 63 moves to HALT and the PC stays at 63.
- **Redirect**
  - Applies in any state.
  - The queue is flushed, PC becomes `redirect_addr`, and there is no push that cycle.
  - The state is unchanged, except that a simultaneous `halt_req` in RUN goes to HALT.
- **Halt**
  - `halt_req` in RUN moves to HALT. No push happens that cycle.
  - The queue continues to drain through the handshake.
  - `start` in HALT resumes RUN from the current PC.
- **Handshake**
  - A pop occurs when `instr_valid` and `instr_ready` are both high.
  - `instr`, `instr_pc` and `instr_valid` are outputs of queue registers, not combinational from `code`.
- **Priority:** `rst` > `redirect_valid` > `halt_req` > `start` > normal fetch.
- **Simultaneous pop and redirect:** the popped instruction counts as delivered, and the remaining entries are flushed.
- **Simultaneous push and pop:** if the queue is full, the occupancy stays 2. If the queue is empty, the pushed word is at the head next cycle and occupancy is 1.
- `start` while already in RUN is ignored.

## Timing
- **Reset values:**
  - PC = `addr_code` = `RESET_PC`.
  - `instr` = 0, `instr_pc` = 0, `instr_valid` = 0, `halted` = 0.
  - Queue empty, state IDLE.
  - Reset mid-operation discards all queue contents on that edge.
- **Start latency:** `start` sampled at edge E gives RUN after E. The first push is at E+1, so `instr_valid` is high after E+1.
- **Redirect latency:** redirect sampled at edge E gives `addr_code` = target after E. The target is pushed at E+1, so `instr_valid` is high for the target after E+1. `instr_valid` is 0 between E and E+1.
- **Throughput:** one instruction per cycle with `instr_ready` held high.
- **Backpressure:** with `instr_ready` low from an empty queue in RUN, the queue fills after 2 pushes. Then `addr_code` holds at the third address.
- **`halted` timing:** `halted` rises in the cycle after the `halt_req` edge or the wrap-stop edge. It falls in the cycle after the `start` edge.

## Structure
- Shared package `cpu_pkg`:
  - `IMEM_AW` = 6 and `INSTR_W` = 32.
  - Fetch state enum `FETCH_IDLE` / `FETCH_RUN` / `FETCH_HALT`.
- Sub-module `fetch_queue`:
  - 2-entry synchronous FIFO of {pc, instr}.
  - Ports: push, pop, flush, full, empty, head.
  - Rule: flush overrides push on the same edge; pop and flush on the same edge is legal.
- `fetch_ctrl` contains the FSM, the PC and the priority logic, and instantiates `fetch_queue`.
- The bench instantiates `fetch_ctrl` together with the real `insmem`.

## Test plan
- **Reset then start:** `rst` for 2 cycles, then `start` 1 cycle, `instr_ready`=1. Expect `addr_code` 0,1,2,… and `instr_pc` 0,1,2,… on consecutive cycles. `instr` must equal the `insmem` word at each address. `instr_valid` is high 2 edges after `start`.
- **Backpressure:** `instr_ready`=0 from PC 4. Expect the queue to hold {4,5}, `addr_code` to stick at 6, and `instr_valid`=1. After `instr_ready`=1: `instr_pc` 4,5,6,… with no gap or duplicate.
- **Redirect with pop:** at `instr_pc`=3 with `instr_ready`=1, assert `redirect_valid` with `redirect_addr`=6'd20. Expect 3 delivered, then `instr_valid`=0 for one cycle, then `instr_pc` 20,21,…. No address 4 is ever delivered.
- **Halt/resume:** `halt_req` at PC 10. Expect `halted`=1, the queued entries to drain, then `instr_valid`=0 and `addr_code` held at 10. `start` resumes with `instr_pc` 10.
- **Wrap:** with `WRAP`=1, redirect to 62. Expect `instr_pc` 62,63,0,1. With `WRAP`=0, expect delivery of 62,63, then `halted`=1 and `addr_code`=63.
- **Reset mid-run:** `rst` while the queue is full. The next cycle must show `instr_valid`=0, `addr_code`=`RESET_PC` and state IDLE. No fetch occurs until `start`.
